usrmux_arb: RTL and testbench

- Two-requester round-robin arbiter sharing one downstream non-linear op unit.
- Selects and forwards one requester's operand per handshake through the shared usrmux select path.
- Records the owner of every accepted request in an in-order tag FIFO.
- Routes the unit's in-order results back to the owning requester.

---
 rtl/usrmux_arb_pkg.sv | 16 +
 rtl/usrmux.sv | 13 +
 rtl/usrtagfifo.sv | 65 ++++++
 rtl/usrmux_arb.sv | 134 +++++++++++++
 tb/tb_usrmux_arb.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usrmux_arb_pkg.sv
// Shared types and sizing helpers for the usrmux_arb requester/result arbiter.
package usrmux_arb_pkg;

  typedef logic [0:0] port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

  localparam int DEFAULT_DEPTH = 4;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/usrmux.sv
// Two-input operand select feeding the shared non-linear op unit.
module usrmux #(
  parameter int WIDTH = 64
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/usrtagfifo.sv
// In-order owner-tag FIFO: one port_id_t per accepted request, popped as results return.
module usrtagfifo
  import usrmux_arb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  port_id_t                  tag_i,
  input  logic                      pop_i,
  output port_id_t                  head_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  port_id_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Self-protecting: an illegal push/pop is ignored rather than corrupting the pointers.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= tag_i;
  end

endmodule

// File: rtl/usrmux_arb.sv
// Two-requester arbiter for one shared op unit, routing in-order results back to owners.
// Define USRMUX_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module usrmux_arb
  import usrmux_arb_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int RWIDTH = 64,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [WIDTH-1:0]        req0_data,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [WIDTH-1:0]        req1_data,
  output logic                    dp_sel,
  output logic                    dp_valid,
  input  logic                    dp_ready,
  output logic [WIDTH-1:0]        dp_data,
  input  logic                    rsp_valid,
  output logic                    rsp_ready,
  input  logic [RWIDTH-1:0]       rsp_data,
  output logic                    rsp0_valid,
  input  logic                    rsp0_ready,
  output logic [RWIDTH-1:0]       rsp0_data,
  output logic                    rsp1_valid,
  input  logic                    rsp1_ready,
  output logic [RWIDTH-1:0]       rsp1_data,
  output logic [cnt_w(DEPTH)-1:0] outstanding,
  output logic                    err
);

  localparam int CW = cnt_w(DEPTH);

  port_id_t      grant, head;
  port_id_t      idle_sel, contend_sel;
  port_id_t      lock_id_q, lock_id_d;
  logic          lock_q, lock_d;
  logic          lock_live;
  logic          err_q, err_d;
  logic          full, empty;
  logic          push, pop;
  logic [CW-1:0] count;

`ifdef USRMUX_ARB_FIXED_PRIO_EN
  assign idle_sel    = PORT0;
  assign contend_sel = PORT0;
`else
  port_id_t last_grant_q, last_grant_d;

  assign last_grant_d = push ? grant : last_grant_q;
  assign idle_sel     = last_grant_q;
  assign contend_sel  = ~last_grant_q;

  always_ff @(posedge clk) begin
    if (!rst_n) last_grant_q <= PORT1;
    else        last_grant_q <= last_grant_d;
  end
`endif

  // A winner offered but stalled by dp_ready keeps the grant until accepted or withdrawn.
  assign lock_live = lock_q & ((lock_id_q == PORT1) ? req1_valid : req0_valid);

  always_comb begin
    grant = idle_sel;
    if (lock_live)                     grant = lock_id_q;
    else if (req0_valid && req1_valid) grant = contend_sel;
    else if (req0_valid)               grant = PORT0;
    else if (req1_valid)               grant = PORT1;
  end

  assign dp_sel     = grant;
  assign dp_valid   = rst_n & (req0_valid | req1_valid) & ~full;
  assign req0_ready = rst_n & dp_ready & ~full & (grant == PORT0);
  assign req1_ready = rst_n & dp_ready & ~full & (grant == PORT1);
  assign push       = dp_valid & dp_ready;

  assign lock_d    = dp_valid & ~dp_ready;
  assign lock_id_d = grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= PORT0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  usrmux #(
    .WIDTH (WIDTH)
  ) u_usrmux (
    .sel_i (dp_sel),
    .in0_i (req0_data),
    .in1_i (req1_data),
    .out_o (dp_data)
  );

  usrtagfifo #(
    .DEPTH (DEPTH)
  ) u_tagfifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .tag_i   (grant),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign rsp0_valid = rst_n & rsp_valid & ~empty & (head == PORT0);
  assign rsp1_valid = rst_n & rsp_valid & ~empty & (head == PORT1);
  assign rsp_ready  = rst_n & ~empty & ((head == PORT1) ? rsp1_ready : rsp0_ready);
  assign rsp0_data  = rsp_data;
  assign rsp1_data  = rsp_data;
  assign pop        = rsp_valid & rsp_ready;

  // A result with no tag to own it means the unit and this arbiter have lost sync.
  assign err_d = err_q | (rsp_valid & empty);

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign outstanding = count;
  assign err         = err_q;

endmodule

// File: tb/tb_usrmux_arb.sv
// Self-checking bench for usrmux_arb: directed scenarios plus randomized traffic vs a queue model.
`timescale 1ns/1ps
module tb_usrmux_arb;
  import usrmux_arb_pkg::*;

  localparam int WIDTH  = 64;
  localparam int RWIDTH = 64;
  localparam int DEPTH  = 4;
  localparam int CW     = cnt_w(DEPTH);
`ifdef USRMUX_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req1_valid, req0_ready, req1_ready;
  logic [WIDTH-1:0]  req0_data, req1_data, dp_data;
  logic              dp_sel, dp_valid, dp_ready;
  logic              rsp_valid, rsp_ready, rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [RWIDTH-1:0] rsp_data, rsp0_data, rsp1_data;
  logic [CW-1:0]     outstanding;
  logic              err;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: owners of accepted requests in order, preferred port on contention,
  // port currently offered-but-stalled, sticky error.
  bit mq[$];
  bit m_pref, m_hold_v, m_hold_p, m_err;

  usrmux_arb #(.WIDTH(WIDTH), .RWIDTH(RWIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .dp_sel(dp_sel), .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_data(dp_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  function automatic bit m_grant();
    if (m_hold_v && (m_hold_p ? req1_valid : req0_valid)) return m_hold_p;
    if (req0_valid && req1_valid) return FIXED ? 1'b0 : m_pref;
    if (req0_valid) return 1'b0;
    if (req1_valid) return 1'b1;
    return FIXED ? 1'b0 : !m_pref;
  endfunction

  task automatic model_tick();
    bit g, full, empty, dv, acc, pop;
    if (!rst_n) begin
      mq.delete();
      m_pref = 1'b0; m_hold_v = 1'b0; m_hold_p = 1'b0; m_err = 1'b0;
      return;
    end
    g     = m_grant();
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    dv    = (req0_valid || req1_valid) && !full;
    acc   = dv && dp_ready;
    pop   = rsp_valid && !empty && (mq[0] ? rsp1_ready : rsp0_ready);
    if (rsp_valid && empty) m_err = 1'b1;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(g);
      if (!FIXED) m_pref = !g;
    end
    m_hold_v = dv && !dp_ready;
    m_hold_p = g;
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; dp_ready = 0;
    rsp_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    req0_valid = 1; req1_valid = 1; dp_ready = 1;
    rsp_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    #1;
    n_cmp++;
    if ({dp_valid, req0_ready, req1_ready, rsp_ready, rsp0_valid, rsp1_valid} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_forced_low: got %b want 000000",
               {dp_valid, req0_ready, req1_ready, rsp_ready, rsp0_valid, rsp1_valid});
    end
    tick(); tick();
    idle_inputs();
    rst_n = 1;
    #1;
    n_cmp++;
    if (outstanding !== '0) begin n_bad++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++;
    if (dp_sel !== m_grant()) begin n_bad++; $display("FAIL reset_idle_sel: got %b want %b", dp_sel, m_grant()); end
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1; req0_data = 64'hA5; dp_ready = 1;
    #1;
    n_cmp++;
    if ({dp_sel, dp_valid, req0_ready, req1_ready} !== 4'b0110) begin
      n_bad++; $display("FAIL single_grant: got %b want 0110", {dp_sel, dp_valid, req0_ready, req1_ready});
    end
    n_cmp++;
    if (dp_data !== 64'hA5) begin n_bad++; $display("FAIL single_data: got %0h want a5", dp_data); end
    tick();
    req0_valid = 0;
    #1;
    n_cmp++;
    if (outstanding !== CW'(1)) begin n_bad++; $display("FAIL single_outstanding1: got %0d want 1", outstanding); end
    rsp_valid = 1; rsp_data = 64'h11; rsp0_ready = 1;
    #1;
    n_cmp++;
    if ({rsp0_valid, rsp1_valid, rsp_ready} !== 3'b101 || rsp0_data !== 64'h11) begin
      n_bad++; $display("FAIL single_rsp: got v0v1rdy=%b data=%0h want 101 11",
                        {rsp0_valid, rsp1_valid, rsp_ready}, rsp0_data);
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (outstanding !== '0) begin n_bad++; $display("FAIL single_outstanding0: got %0d want 0", outstanding); end
  endtask

  task automatic test_round_robin();
    bit exp;
    do_reset();
    req0_valid = 1; req1_valid = 1; dp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      req0_data = 64'(16'h1000 + i); req1_data = 64'(16'h2000 + i);
      exp = FIXED ? 1'b0 : 1'(i % 2);
      #1;
      n_cmp++;
      if (dp_sel !== exp || dp_data !== (exp ? req1_data : req0_data)) begin
        n_bad++; $display("FAIL rr_grant[%0d]: got sel=%b data=%0h want sel=%b", i, dp_sel, dp_data, exp);
      end
      tick();
    end
    idle_inputs();
    rsp_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      rsp_data = 64'(i + 1);
      exp = FIXED ? 1'b0 : 1'(i % 2);
      #1;
      n_cmp++;
      if ({rsp0_valid, rsp1_valid} !== {!exp, exp} || (exp ? rsp1_data : rsp0_data) !== 64'(i + 1)) begin
        n_bad++; $display("FAIL rr_route[%0d]: got v0v1=%b want %b%b", i, {rsp0_valid, rsp1_valid}, !exp, exp);
      end
      tick();
    end
    idle_inputs();
    #1;
    n_cmp++;
    if (outstanding !== '0) begin n_bad++; $display("FAIL rr_drain: got %0d want 0", outstanding); end
  endtask

  task automatic test_full();
    do_reset();
    req0_valid = 1; dp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      req0_data = 64'(i);
      #1;
      n_cmp++;
      if ({dp_valid, req0_ready} !== {2{i < 4}}) begin
        n_bad++; $display("FAIL full_accept[%0d]: got vr=%b want %b", i, {dp_valid, req0_ready}, {2{i < 4}});
      end
      tick();
    end
    n_cmp++;
    if (outstanding !== CW'(DEPTH)) begin n_bad++; $display("FAIL full_count: got %0d want %0d", outstanding, DEPTH); end
    rsp_valid = 1; rsp0_ready = 1; rsp_data = 64'h77;
    #1;
    n_cmp++;
    if ({dp_valid, req0_ready, rsp_ready} !== 3'b001) begin
      n_bad++; $display("FAIL full_no_pushthrough: got %b want 001", {dp_valid, req0_ready, rsp_ready});
    end
    tick();
    rsp_valid = 0;
    #1;
    n_cmp++;
    if (outstanding !== CW'(DEPTH - 1) || req0_ready !== 1'b1) begin
      n_bad++; $display("FAIL full_after_pop: got cnt=%0d rdy=%b want %0d 1", outstanding, req0_ready, DEPTH - 1);
    end
    tick();
    #1;
    n_cmp++;
    if (outstanding !== CW'(DEPTH) || dp_valid !== 1'b0) begin
      n_bad++; $display("FAIL full_refill: got cnt=%0d dv=%b want %0d 0", outstanding, dp_valid, DEPTH);
    end
    idle_inputs();
    rsp_valid = 1; rsp0_ready = 1;
    for (int i = 0; i < DEPTH; i++) tick();
    idle_inputs();
  endtask

  task automatic test_hold();
    logic [WIDTH-1:0] d1;
    do_reset();
    d1 = {$urandom, $urandom};
    req1_valid = 1; req1_data = d1; dp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      if (i >= 1) begin req0_valid = 1; req0_data = {$urandom, $urandom}; end
      #1;
      n_cmp++;
      if ({dp_sel, dp_valid, req1_ready, req0_ready} !== 4'b1100 || dp_data !== d1) begin
        n_bad++; $display("FAIL hold[%0d]: got sel/v/r1/r0=%b data=%0h want 1100 %0h",
                          i, {dp_sel, dp_valid, req1_ready, req0_ready}, dp_data, d1);
      end
      tick();
    end
    dp_ready = 1;
    #1;
    n_cmp++;
    if ({dp_sel, req1_ready} !== 2'b11) begin n_bad++; $display("FAIL hold_accept: got %b want 11", {dp_sel, req1_ready}); end
    tick();
    #1;
    n_cmp++;
    if ({dp_sel, req0_ready} !== 2'b01) begin n_bad++; $display("FAIL hold_next: got %b want 01", {dp_sel, req0_ready}); end
    tick();
    idle_inputs();
    rsp_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    tick(); tick();
    idle_inputs();
  endtask

  task automatic test_rsp_backpressure();
    do_reset();
    req1_valid = 1; dp_ready = 1;
    tick();
    idle_inputs();
    rsp_valid = 1; rsp0_ready = 1; rsp1_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if ({rsp_ready, rsp0_valid, rsp1_valid} !== 3'b001 || outstanding !== CW'(1)) begin
        n_bad++; $display("FAIL rsp_bp[%0d]: got rdy/v0/v1=%b cnt=%0d want 001 1",
                          i, {rsp_ready, rsp0_valid, rsp1_valid}, outstanding);
      end
      tick();
    end
    rsp1_ready = 1;
    #1;
    n_cmp++;
    if (rsp_ready !== 1'b1) begin n_bad++; $display("FAIL rsp_bp_release: got %b want 1", rsp_ready); end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (outstanding !== '0) begin n_bad++; $display("FAIL rsp_bp_drain: got %0d want 0", outstanding); end
  endtask

  task automatic test_err();
    do_reset();
    rsp_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    #1;
    n_cmp++;
    if ({rsp_ready, rsp0_valid, rsp1_valid} !== 3'b000) begin
      n_bad++; $display("FAIL err_no_route: got %b want 000", {rsp_ready, rsp0_valid, rsp1_valid});
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", err); end
    tick(); tick();
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err); end
    req0_valid = 1; dp_ready = 1;
    tick(); tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (outstanding !== CW'(2)) begin n_bad++; $display("FAIL err_pre_reset: got %0d want 2", outstanding); end
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    n_cmp++;
    if (err !== 1'b0 || outstanding !== '0) begin
      n_bad++; $display("FAIL err_reset: got err=%b cnt=%0d want 0 0", err, outstanding);
    end
    rsp_valid = 1; rsp0_ready = 1;
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL err_stale_result: got %b want 1", err); end
  endtask

  task automatic test_random();
    bit ef, ee, eg, eh;
    logic [6:0] exp_v, got_v;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(9) < 7);
      req1_valid = ($urandom_range(9) < 7);
      req0_data  = {$urandom, $urandom};
      req1_data  = {$urandom, $urandom};
      dp_ready   = ($urandom_range(9) < 6);
      rsp_valid  = (mq.size() > 0) && ($urandom_range(1) == 1);
      rsp0_ready = ($urandom_range(3) != 0);
      rsp1_ready = ($urandom_range(3) != 0);
      rsp_data   = {$urandom, $urandom};
      #1;
      ef = (mq.size() == DEPTH);
      ee = (mq.size() == 0);
      eg = m_grant();
      eh = ee ? 1'b0 : mq[0];
      exp_v = {eg,
               (req0_valid || req1_valid) && !ef,
               dp_ready && !ef && !eg,
               dp_ready && !ef && eg,
               !ee && (eh ? rsp1_ready : rsp0_ready),
               rsp_valid && !ee && !eh,
               rsp_valid && !ee && eh};
      got_v = {dp_sel, dp_valid, req0_ready, req1_ready, rsp_ready, rsp0_valid, rsp1_valid};
      n_cmp++;
      if (got_v !== exp_v || dp_data !== (eg ? req1_data : req0_data)) begin
        n_bad++; $display("FAIL rand_ctl[%0d]: got %b data=%0h want %b", i, got_v, dp_data, exp_v);
      end
      n_cmp++;
      if (outstanding !== CW'(mq.size()) || err !== m_err || rsp0_data !== rsp_data || rsp1_data !== rsp_data) begin
        n_bad++; $display("FAIL rand_state[%0d]: got cnt=%0d err=%b want cnt=%0d err=%b",
                          i, outstanding, err, mq.size(), m_err);
      end
      tick();
    end
    idle_inputs();
  endtask

`ifdef USRMUX_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    do_reset();
    req0_valid = 1; req1_valid = 1; dp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({dp_sel, req0_ready} !== 2'b01) begin
        n_bad++; $display("FAIL fixed_prio[%0d]: got %b want 01", i, {dp_sel, req0_ready});
      end
      tick();
    end
    idle_inputs();
  endtask
`endif

  initial begin
    rst_n = 0;
    idle_inputs();
    req0_data = '0; req1_data = '0; rsp_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_hold();
    test_rsp_backpressure();
    test_err();
    test_random();
`ifdef USRMUX_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
